// File: rtl/oflow_registration_set_scheduler_if.sv
// Handshake bundle between core control, the scheduler and the score engines.
// slave = scheduler side, master = control/engine side.
interface oflow_registration_set_scheduler_if #(
  parameter int SET_W   = 4,
  parameter int ID_W    = 12,
  parameter int FRAME_W = 16
);
  logic               start_registration;
  logic [FRAME_W-1:0] frame_num;
  logic [SET_W-1:0]   num_of_sets;
  logic               start_score_calc;
  logic               done_score_calc;
  logic [SET_W-1:0]   calc_set_idx;
  logic               start_score_board;
  logic               done_score_board;
  logic [SET_W-1:0]   row_sel_by_set;
  logic [ID_W-1:0]    id_base;
  logic               first_frame;
  logic               busy;
  logic               done_registration;

  modport master (
    output start_registration, frame_num, num_of_sets,
    output done_score_calc, done_score_board,
    input  start_score_calc, calc_set_idx,
    input  start_score_board, row_sel_by_set,
    input  id_base, first_frame, busy, done_registration
  );

  modport slave (
    input  start_registration, frame_num, num_of_sets,
    input  done_score_calc, done_score_board,
    output start_score_calc, calc_set_idx,
    output start_score_board, row_sel_by_set,
    output id_base, first_frame, busy, done_registration
  );
endinterface

// File: rtl/oflow_registration_set_scheduler.sv
// Per-set registration scheduler: pipelines score calc (set k+1) with score
// board (set k). Ports: clk, reset_N (sync, active-high), bus (slave modport).
module oflow_registration_set_scheduler #(
  parameter int SET_W  = 4,
  parameter int PE_NUM = 24,
  parameter int ID_W   = 12
) (
  input  logic clk,
  input  logic reset_N,
  oflow_registration_set_scheduler_if.slave bus
);
  localparam int NSLOT = 1 << SET_W;

  typedef enum logic [1:0] {
    C_IDLE, C_ISSUE, C_WAIT
  } calc_st_e;

  typedef enum logic [1:0] {
    B_IDLE, B_ISSUE, B_WAIT, B_FINISH
  } brd_st_e;

  calc_st_e         c_st_q, c_st_d;
  brd_st_e          b_st_q, b_st_d;
  logic [SET_W-1:0] nsets_q, nsets_d;
  logic [SET_W-1:0] c_idx_q, c_idx_d;
  logic [SET_W-1:0] r_idx_q, r_idx_d;
  logic [NSLOT-1:0] ready_q, ready_d;
  logic             first_q, first_d;
  logic             accept, c_go, b_go, busy;
  logic [SET_W:0]   c_ext, r_ext, n_ext;
  logic [ID_W-1:0]  base;

  // Widened copies so lookahead and end tests never wrap at 2^SET_W-1.
  assign c_ext = {1'b0, c_idx_q};
  assign r_ext = {1'b0, r_idx_q};
  assign n_ext = {1'b0, nsets_q};

  assign busy   = (b_st_q != B_IDLE);
  assign accept = bus.start_registration && !busy;

  // One-set lookahead: the result buffer holds a single set.
  assign c_go = (c_st_q == C_ISSUE) && (c_ext < n_ext)
              && (c_ext <= r_ext + 1'b1);
  assign b_go = (b_st_q == B_ISSUE) && (r_ext < n_ext)
              && (first_q || ready_q[r_idx_q]);

  always_comb begin
    c_st_d  = c_st_q;
    b_st_d  = b_st_q;
    nsets_d = nsets_q;
    c_idx_d = c_idx_q;
    r_idx_d = r_idx_q;
    ready_d = ready_q;
    first_d = first_q;
    if (accept) begin
      nsets_d = bus.num_of_sets;
      first_d = (bus.frame_num == '0);
      c_idx_d = '0;
      r_idx_d = '0;
      ready_d = '0;
      c_st_d  = first_d ? C_IDLE : C_ISSUE;
      b_st_d  = B_ISSUE;
    end else begin
      unique case (c_st_q)
        C_ISSUE: begin
          if (c_ext >= n_ext) c_st_d = C_IDLE;
          else if (c_go)      c_st_d = C_WAIT;
        end
        C_WAIT: begin
          if (bus.done_score_calc) begin
            ready_d[c_idx_q] = 1'b1;
            c_idx_d = c_idx_q + 1'b1;
            c_st_d = (c_ext + 1'b1 == n_ext) ? C_IDLE : C_ISSUE;
          end
        end
        default: ;
      endcase
      unique case (b_st_q)
        B_ISSUE: begin
          if (r_ext >= n_ext) b_st_d = B_FINISH;
          else if (b_go)      b_st_d = B_WAIT;
        end
        B_WAIT: begin
          if (bus.done_score_board) begin
            r_idx_d = r_idx_q + 1'b1;
            b_st_d = (r_ext + 1'b1 == n_ext) ? B_FINISH : B_ISSUE;
          end
        end
        B_FINISH: b_st_d = B_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_N) begin
      c_st_q  <= C_IDLE;
      b_st_q  <= B_IDLE;
      nsets_q <= '0;
      c_idx_q <= '0;
      r_idx_q <= '0;
      ready_q <= '0;
      first_q <= 1'b0;
    end else begin
      c_st_q  <= c_st_d;
      b_st_q  <= b_st_d;
      nsets_q <= nsets_d;
      c_idx_q <= c_idx_d;
      r_idx_q <= r_idx_d;
      ready_q <= ready_d;
      first_q <= first_d;
    end
  end

  // ID base is only meaningful while a frame is in flight; held at 0 otherwise.
  assign base = ID_W'(r_idx_q) * ID_W'(PE_NUM) + ID_W'(1);

  assign bus.start_score_calc  = c_go;
  assign bus.calc_set_idx      = c_idx_q;
  assign bus.start_score_board = b_go;
  assign bus.row_sel_by_set    = r_idx_q;
  assign bus.id_base           = busy ? base : '0;
  assign bus.first_frame       = first_q;
  assign bus.busy              = busy;
  assign bus.done_registration = (b_st_q == B_FINISH);
endmodule

// File: tb/tb_oflow_registration_set_scheduler.sv
// Randomized + directed bench for oflow_registration_set_scheduler,
// checked every cycle against a behavioural model of the set pipeline.
module tb_oflow_registration_set_scheduler;
  localparam int SET_W = 4;
  localparam int ID_W = 12;
  localparam int FRAME_W = 16;
  localparam int PE_NUM = 24;

  logic clk = 1'b0;
  logic reset_N = 1'b1;
  always #5 clk = ~clk;

  oflow_registration_set_scheduler_if #(
    .SET_W(SET_W), .ID_W(ID_W), .FRAME_W(FRAME_W)
  ) bus ();

  oflow_registration_set_scheduler #(
    .SET_W(SET_W), .PE_NUM(PE_NUM), .ID_W(ID_W)
  ) dut (
    .clk(clk),
    .reset_N(reset_N),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  bit m_busy, m_first, m_ca, m_cw, m_bw, m_fin;
  int m_n, m_c, m_r;
  bit m_ready [16];

  // engines
  int c_cnt, b_cnt, c_lat, b_lat;
  bit stray_en;

  // event logs
  int n_done, n_sc, n_sb, n_both, n_busy, last_done_cyc;
  int ids[$];

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_first = 0; m_ca = 0; m_cw = 0; m_bw = 0; m_fin = 0;
    m_n = 0; m_c = 0; m_r = 0;
    foreach (m_ready[i]) m_ready[i] = 0;
  endtask

  task automatic clear_logs();
    n_done = 0; n_sc = 0; n_sb = 0; n_both = 0; n_busy = 0;
    last_done_cyc = -1;
    ids.delete();
  endtask

  task automatic step(bit st, bit rst);
    bit e_sc, e_sb, dc, db;
    int e_id;
    e_sc = m_busy && m_ca && !m_cw && m_c < m_n && m_c <= m_r + 1;
    e_sb = m_busy && !m_fin && !m_bw && m_r < m_n
         && (m_first || m_ready[m_r]);
    e_id = m_busy ? m_r * PE_NUM + 1 : 0;
    chk("start_score_calc", bus.start_score_calc, e_sc);
    chk("start_score_board", bus.start_score_board, e_sb);
    chk("calc_set_idx", bus.calc_set_idx, m_c);
    chk("row_sel_by_set", bus.row_sel_by_set, m_r);
    chk("id_base", bus.id_base, e_id);
    chk("first_frame", bus.first_frame, m_first);
    chk("busy", bus.busy, m_busy);
    chk("done_registration", bus.done_registration, m_fin);

    if (bus.done_registration) begin
      n_done++;
      last_done_cyc = cyc;
    end
    if (bus.start_score_calc) n_sc++;
    if (bus.start_score_board) begin
      n_sb++;
      ids.push_back(int'(bus.id_base));
    end
    if (bus.start_score_calc && bus.start_score_board) n_both++;
    if (bus.busy) n_busy++;

    dc = 0;
    if (c_cnt > 0) begin
      c_cnt--;
      if (c_cnt == 0) dc = 1;
    end else if (stray_en && $urandom_range(0, 9) == 0) dc = 1;
    db = 0;
    if (b_cnt > 0) begin
      b_cnt--;
      if (b_cnt == 0) db = 1;
    end else if (stray_en && $urandom_range(0, 9) == 0) db = 1;
    if (bus.start_score_calc) c_cnt = c_lat;
    if (bus.start_score_board) b_cnt = b_lat;
    if (rst) begin
      c_cnt = 0;
      b_cnt = 0;
    end

    bus.done_score_calc = dc;
    bus.done_score_board = db;
    bus.start_registration = st;
    reset_N = rst;

    if (rst) model_reset();
    else if (!m_busy) begin
      if (st) begin
        m_busy = 1;
        m_n = int'(bus.num_of_sets);
        m_first = (bus.frame_num == 0);
        m_ca = !m_first;
        m_c = 0; m_r = 0;
        m_cw = 0; m_bw = 0; m_fin = 0;
        foreach (m_ready[i]) m_ready[i] = 0;
      end
    end else if (m_fin) begin
      m_busy = 0;
      m_fin = 0;
    end else begin
      if (e_sc) m_cw = 1;
      else if (m_cw && dc) begin
        m_ready[m_c] = 1;
        m_c++;
        m_cw = 0;
      end
      if (e_sb) m_bw = 1;
      else if (m_bw && db) begin
        m_r++;
        m_bw = 0;
        if (m_r == m_n) m_fin = 1;
      end else if (!m_bw && m_r >= m_n) m_fin = 1;
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle(int budget);
    int k;
    k = 0;
    while (m_busy && k < budget) begin
      step(0, 0);
      k++;
    end
    if (m_busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_frame(int fr, int n, int lc, int lb, output int t0);
    bus.frame_num = FRAME_W'(fr);
    bus.num_of_sets = SET_W'(n);
    c_lat = lc;
    b_lat = lb;
    clear_logs();
    t0 = cyc;
    step(1, 0);
    wait_idle(2000);
    step(0, 0);
  endtask

  initial begin
    int t0, k;
    bus.start_registration = 0;
    bus.frame_num = '0;
    bus.num_of_sets = '0;
    bus.done_score_calc = 0;
    bus.done_score_board = 0;
    c_cnt = 0; b_cnt = 0; c_lat = 1; b_lat = 1; stray_en = 0;
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset_N = 0;
    step(0, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_id_base", bus.id_base, 0);

    // frame 5, three sets
    run_frame(5, 3, 4, 6, t0);
    chk("t1_done_count", n_done, 1);
    chk("t1_calc_count", n_sc, 3);
    chk("t1_board_count", n_sb, 3);

    // first frame, two sets
    run_frame(0, 2, 2, 3, t0);
    chk("t2_calc_count", n_sc, 0);
    chk("t2_board_count", ids.size(), 2);
    if (ids.size() == 2) begin
      chk("t2_id0", ids[0], 1);
      chk("t2_id1", ids[1], 25);
    end
    chk("t2_done_count", n_done, 1);

    // zero sets
    run_frame(9, 0, 2, 2, t0);
    chk("t3_pulses", n_sc + n_sb, 0);
    chk("t3_done_at", last_done_cyc - t0, 2);
    chk("t3_busy_cycles", n_busy, 2);

    // simultaneous calc/board done
    run_frame(7, 3, 3, 3, t0);
    chk("t4_both_cycles", n_both, 2);
    chk("t4_done_at", last_done_cyc - t0, 17);

    // start while busy, then strays in idle
    bus.frame_num = 16'd11;
    bus.num_of_sets = 4'd2;
    c_lat = 2; b_lat = 2;
    clear_logs();
    step(1, 0);
    repeat (3) step(0, 0);
    bus.frame_num = 16'd0;
    bus.num_of_sets = 4'd9;
    step(1, 0);
    wait_idle(500);
    chk("t5_board_count", n_sb, 2);
    chk("t5_calc_count", n_sc, 2);
    clear_logs();
    stray_en = 1;
    repeat (20) step(0, 0);
    stray_en = 0;
    chk("t5_idle_pulses", n_sc + n_sb + n_done, 0);
    chk("t5_row_hold", bus.row_sel_by_set, 2);

    // reset mid-frame with board set 1 in flight
    bus.frame_num = 16'd3;
    bus.num_of_sets = 4'd4;
    c_lat = 3; b_lat = 5;
    step(1, 0);
    k = 0;
    while (!(m_bw && m_r == 1) && k < 200) begin
      step(0, 0);
      k++;
    end
    chk("t6_reached_wait", m_bw && m_r == 1, 1);
    step(0, 1);
    step(0, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_row", bus.row_sel_by_set, 0);
    chk("t6_first", bus.first_frame, 0);
    run_frame(4, 2, 1, 2, t0);
    chk("t6_rerun_done", n_done, 1);
    chk("t6_rerun_board", n_sb, 2);

    // maximum set count
    run_frame(0, 15, 1, 1, t0);
    chk("max_first_board", n_sb, 15);
    if (ids.size() == 15) chk("max_last_id", ids[14], 14 * PE_NUM + 1);
    run_frame(2, 15, 2, 1, t0);
    chk("max_calc", n_sc, 15);
    chk("max_board", n_sb, 15);

    // randomized frames with stray pulses, busy starts and resets
    for (int f = 0; f < 60; f++) begin
      bus.frame_num = ($urandom_range(0, 3) == 0) ? 16'd0
                    : FRAME_W'($urandom_range(1, 60000));
      bus.num_of_sets = SET_W'($urandom_range(0, 15));
      c_lat = $urandom_range(1, 6);
      b_lat = $urandom_range(1, 6);
      stray_en = ($urandom_range(0, 1) == 1);
      step(1, 0);
      k = 0;
      while (m_busy && k < 2000) begin
        bus.num_of_sets = SET_W'($urandom_range(0, 15));
        step($urandom_range(0, 9) == 0, $urandom_range(0, 299) == 0);
        k++;
      end
      if (m_busy) chk("rand_timeout", 1, 0);
      stray_en = 0;
      step(0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
